winograd_tile_arbiter: RTL
==========================

Name: winograd_tile_arbiter

Overview:
- Shares one Winograd F(4x4,3x3) tile engine (tile_controller: 6x6 tile + 3x3 kernel in, 4x4 result out, start/done pulse interface) between N_REQ independent convolution sequencers.
- Each requester offers one tile job at a time. The arbiter grants round-robin, latches the operands, drives the engine, captures the result and returns it with a response handshake.
- It sits between the conv sequencers (e.g. 10x12 image conv FSMs) and the single engine instance.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ID_W, 3, width of the requester ID field (must satisfy 2^ID_W >= N_REQ).
- TIMEOUT, 1024, engine watchdog limit in cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  bit r: requester r has a job. Held until accepted.
- req_ready  out  N_REQ  bit r: job r accepted this cycle (one-hot or zero).
- req_kernel  in  N_REQ*144  per-requester 3x3x16 kernel, row-major, element [0][0] in LSBs.
- req_tile  in  N_REQ*576  per-requester 6x6x16 tile, row-major.
- rsp_valid  out  1  result available.
- rsp_id  out  ID_W  requester the result belongs to.
- rsp_data  out  256  4x4x16 result, row-major.
- rsp_err  out  1  result is invalid (timeout). Constant 0 without ARB_TIMEOUT_EN.
- rsp_ready  in  1  consumer accepts the response.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_kernel  out  144  latched kernel to the engine.
- eng_tile  out  576  latched tile to the engine.
- eng_result  in  256  engine result; valid when eng_done=1.
- eng_done  in  1  engine completion pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, eng_start=0, eng_kernel=0, eng_tile=0, busy=0, rr_ptr=0, state=IDLE.
- Reset asserted in any state returns the block to IDLE next cycle. An in-flight engine job is abandoned; a late eng_done arriving in IDLE is ignored.
- State IDLE:
  - Round-robin search of req_valid starting at index rr_ptr, wrapping modulo N_REQ. First set bit wins (g).
  - When a winner exists: req_ready[g]=1 combinationally for that cycle; eng_kernel/eng_tile are registered from slice g; grant_id is registered as g; go to ISSUE.
  - With no request, stay in IDLE.
- State ISSUE: eng_start=1 for exactly this cycle; go to WAIT. Accept-to-start latency is 1 cycle.
- State WAIT:
  - On eng_done=1: rsp_data <= eng_result, rsp_id <= grant_id, rsp_err <= 0, rsp_valid <= 1; go to RESP.
  - eng_done during ISSUE or IDLE is ignored.
- State RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On rsp_ready: rsp_valid <= 0; rr_ptr <= (grant_id+1) mod N_REQ; go to IDLE.
  - No new grant is made in the same cycle. Minimum job period = accept + issue + engine latency + 1 response cycle + 1 IDLE cycle.
- Fairness:
  - Requesters that stay continuously valid are served strictly in rotation.
  - With N_REQ=3 and all valid from reset, the grant order is 0,1,2,0,...
- req_ready is never asserted outside IDLE, and never for a requester whose req_valid is 0.
- Requester operands only need to be stable in the accept cycle. eng_kernel and eng_tile hold the latched values until the next accept.
- rsp_ready while rsp_valid=0 has no effect.
- busy = (state != IDLE).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 with no eng_done: rsp_valid <= 1, rsp_err <= 1, rsp_data <= 0, rsp_id <= grant_id; go to RESP.
  - If eng_done and the limit coincide, eng_done wins (rsp_err=0).
  - After a timeout, a stale eng_done is ignored in all states except WAIT of a later job.
- Not defined: no counter, WAIT has no exit except eng_done, rsp_err tied to 0.

Test Plan:
- Reset/idle: rst high 3 cycles then low, no requests → all outputs 0, busy=0, eng_start never pulses over 20 cycles.
- Single job: N_REQ=2, req_valid=2'b10, tile elements = index 0..35, kernel = all 1; engine stub returns done after 5 cycles with result = 16'h00A5 per element →
  - req_ready=2'b10 for exactly 1 cycle;
  - eng_start 1 cycle later, eng_tile equal to the driven tile;
  - rsp_valid with rsp_id=1 and rsp_data all 16'h00A5.
- Round-robin: N_REQ=3, all req_valid held high, rsp_ready tied 1 → grant sequence 0,1,2,0,1,2 over 6 jobs; no requester granted twice in a row.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_data/rsp_id stable, busy=1, no req_ready pulses; release rsp_ready → rsp_valid drops next cycle and the next grant follows one cycle later.
- Reset mid-job: assert rst in WAIT, deassert, then give the engine stub's eng_done 2 cycles later → state IDLE, rsp_valid stays 0, no spurious eng_start.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=16): stub never asserts done → rsp_valid with rsp_err=1 and rsp_data=0 exactly 16 cycles after entering WAIT; the next job completes normally with rsp_err=0.

Source files
------------

// File: rtl/winograd_tile_arbiter.sv
// Round-robin arbiter sharing one Winograd F(4x4,3x3) tile engine between N_REQ conv sequencers.
// Optional engine watchdog enabled by defining ARB_TIMEOUT_EN (limit set by TIMEOUT).
module winograd_tile_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ID_W    = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*144-1:0]   req_kernel,
    input  logic [N_REQ*576-1:0]   req_tile,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [255:0]           rsp_data,
    output logic                   rsp_err,
    input  logic                   rsp_ready,
    output logic                   eng_start,
    output logic [143:0]           eng_kernel,
    output logic [575:0]           eng_tile,
    input  logic [255:0]           eng_result,
    input  logic                   eng_done,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // Elaboration-time guard against parameter sets the ID field cannot represent.
    if ((1 << ID_W) < N_REQ || N_REQ < 2 || TIMEOUT < 2) begin : g_badParams
        $error("winograd_tile_arbiter: illegal N_REQ/ID_W/TIMEOUT combination");
    end

    state_t              r_state;
    state_t              w_nextState;
    logic [ID_W-1:0]     r_rrPtr;
    logic [ID_W-1:0]     r_grantId;
    logic [143:0]        r_engKernel;
    logic [575:0]        r_engTile;
    logic                r_rspValid;
    logic [ID_W-1:0]     r_rspId;
    logic [255:0]        r_rspData;

    logic [N_REQ-1:0]    w_rot;
    logic [ID_W:0]       w_sum;
    logic                w_found;
    logic [ID_W-1:0]     w_grant;
    logic [143:0]        w_selKernel;
    logic [575:0]        w_selTile;
    logic [ID_W-1:0]     w_rrNext;
    logic                w_timeout;

    // Rotate req_valid so bit 0 is the requester at rr_ptr; the first set bit wins.
    always_comb begin
        w_rot   = N_REQ'({req_valid, req_valid} >> r_rrPtr);
        w_found = 1'b0;
        w_sum   = '0;
        w_grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rrPtr} + (ID_W+1)'(k);
                if (w_sum >= (ID_W+1)'(N_REQ)) begin
                    w_sum = w_sum - (ID_W+1)'(N_REQ);
                end
                w_grant = w_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready   = '0;
        w_selKernel = '0;
        w_selTile   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            req_ready[j] = (r_state == S_IDLE) && w_found && (w_grant == ID_W'(j));
            if (w_grant == ID_W'(j)) begin
                w_selKernel = req_kernel[j*144 +: 144];
                w_selTile   = req_tile[j*576 +: 576];
            end
        end
    end

    always_comb begin
        if (r_grantId == ID_W'(N_REQ - 1)) begin
            w_rrNext = '0;
        end else begin
            w_rrNext = r_grantId + ID_W'(1);
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0] r_waitCnt;
    logic          r_rspErr;

    // Watchdog counts WAIT cycles; a coincident eng_done takes priority over expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waitCnt <= '0;
            r_rspErr  <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_waitCnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_waitCnt <= r_waitCnt + TW'(1);
            end
            if (r_state == S_WAIT) begin
                if (eng_done) begin
                    r_rspErr <= 1'b0;
                end else if (w_timeout) begin
                    r_rspErr <= 1'b1;
                end
            end
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !eng_done && (r_waitCnt == TW'(TIMEOUT - 1));
    assign rsp_err   = r_rspErr;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_nextState = S_ISSUE;
            S_ISSUE: w_nextState = S_WAIT;
            S_WAIT:  if (eng_done || w_timeout) w_nextState = S_RESP;
            S_RESP:  if (rsp_ready) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Operands are captured in the accept cycle so requesters may change them right after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rrPtr     <= '0;
            r_grantId   <= '0;
            r_engKernel <= '0;
            r_engTile   <= '0;
            r_rspValid  <= 1'b0;
            r_rspId     <= '0;
            r_rspData   <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_engKernel <= w_selKernel;
                        r_engTile   <= w_selTile;
                        r_grantId   <= w_grant;
                    end
                end
                S_WAIT: begin
                    if (eng_done) begin
                        r_rspData  <= eng_result;
                        r_rspId    <= r_grantId;
                        r_rspValid <= 1'b1;
                    end else if (w_timeout) begin
                        r_rspData  <= '0;
                        r_rspId    <= r_grantId;
                        r_rspValid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_rrPtr    <= w_rrNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign eng_start  = (r_state == S_ISSUE);
    assign eng_kernel = r_engKernel;
    assign eng_tile   = r_engTile;
    assign rsp_valid  = r_rspValid;
    assign rsp_id     = r_rspId;
    assign rsp_data   = r_rspData;
    assign busy       = (r_state != S_IDLE);

endmodule
